// File: rtl/enc_pkg.sv
// Shared definitions for the Gray/binary conversion blocks: the default
// Gray word width and the state type of the iterative decoder.
package enc_pkg;

  // Width of the team's Gray-coded pointer/position words.
  localparam int GRAY_W = 10;

  // Decoder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dec_gray2bin_seq_if.sv
// Handshake bundle of the iterative Gray-to-binary decoder: one valid/ready
// channel carrying the Gray word in, one carrying the binary word out, plus
// a busy indication.
interface dec_gray2bin_seq_if #(
  parameter int W = enc_pkg::GRAY_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_gray;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
  logic         busy;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid,
    output in_gray,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bin,
    input  busy
  );

  // Decoder side.
  modport slave (
    input  in_valid,
    input  in_gray,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bin,
    output busy
  );

  // Passive observer.
  modport monitor (
    input in_valid,
    input in_gray,
    input out_ready,
    input in_ready,
    input out_valid,
    input out_bin,
    input busy
  );

endinterface

// File: rtl/dec_gray2bin_seq_chk.sv
// Protocol properties of the iterative Gray-to-binary decoder: a presented
// result is held unchanged until taken, and the decoder never reports busy
// while offering a result or accepting a word.
module dec_gray2bin_seq_chk #(
  parameter int W = 10
) (
  input logic         clk,
  input logic         rst,
  input logic         in_ready,
  input logic         out_valid,
  input logic         out_ready,
  input logic         busy,
  input logic [W-1:0] out_bin
);

  a_result_held: assert property (
    @(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_bin))
  ) else $error("result dropped or changed under backpressure");

  a_busy_excl_valid: assert property (
    @(posedge clk) disable iff (rst)
    !(out_valid && busy)
  ) else $error("busy and out_valid both high");

  a_ready_not_busy: assert property (
    @(posedge clk) disable iff (rst)
    in_ready |-> !busy
  ) else $error("in_ready high while busy");

endmodule

// File: rtl/dec_gray2bin_seq.sv
// Iterative Gray-to-binary decoder. A Gray word is captured on the input
// handshake, the MSB is copied straight through and the remaining bits are
// resolved one per clock, MSB first, as bin[i] = bin[i+1] ^ gray[i]. The
// finished word is held on a registered output until the consumer takes it.
// In DONE a new word may be accepted on the same edge the result is taken,
// giving one word per W cycles under back-to-back traffic.
module dec_gray2bin_seq
  import enc_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic                clk,
  input  logic                rst,
  dec_gray2bin_seq_if.slave   bus
);

  // Bit index counter is at least one bit wide even for W == 1.
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  // First bit resolved after the MSB; unused when W == 1.
  localparam logic [IW-1:0] IDX_INIT = (W > 1) ? IW'(W - 2) : '0;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [W-1:0]  g_r;
  logic [W-1:0]  g_nxt_s;
  logic [W-1:0]  b_r;
  logic [W-1:0]  b_nxt_s;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_nxt_s;
  logic [W-1:0]  out_bin_r;
  logic [W-1:0]  out_bin_nxt_s;
  logic          out_valid_r;
  logic          busy_r;
  logic          in_ready_s;
  logic          accept_s;

  // The decoder can take a word in IDLE, or in DONE when the held result is
  // being taken in the same cycle; forced low while reset is applied.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else if (state_r == DONE) begin
      in_ready_s = bus.out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and input accept decision.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = (W == 1) ? DONE : CONV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONV: begin
        if (idx_r == '0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CONV;
        end
      end
      DONE: begin
        if (bus.out_ready && bus.in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = (W == 1) ? DONE : CONV;
        end else if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath next values: capture on accept, otherwise resolve one bit per
  // CONV cycle; the result register only loads when DONE is being entered
  // (or re-entered with a fresh word), so partial words are never shown.
  always_comb begin
    g_nxt_s       = g_r;
    b_nxt_s       = b_r;
    idx_nxt_s     = idx_r;
    out_bin_nxt_s = out_bin_r;
    if (accept_s) begin
      g_nxt_s        = bus.in_gray;
      b_nxt_s        = '0;
      b_nxt_s[W-1]   = bus.in_gray[W-1];
      idx_nxt_s      = IDX_INIT;
    end else if (state_r == CONV) begin
      for (int i = 0; i < W - 1; i++) begin
        if (idx_r == IW'(i)) begin
          b_nxt_s[i] = b_r[i+1] ^ g_r[i];
        end else begin
          b_nxt_s[i] = b_r[i];
        end
      end
      if (idx_r != '0) begin
        idx_nxt_s = idx_r - 1'b1;
      end else begin
        idx_nxt_s = idx_r;
      end
    end else begin
      idx_nxt_s = idx_r;
    end
    if ((state_nxt_s == DONE) && ((state_r != DONE) || accept_s)) begin
      out_bin_nxt_s = b_nxt_s;
    end else begin
      out_bin_nxt_s = out_bin_r;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_r         <= '0;
      b_r         <= '0;
      idx_r       <= '0;
      out_bin_r   <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      g_r         <= g_nxt_s;
      b_r         <= b_nxt_s;
      idx_r       <= idx_nxt_s;
      out_bin_r   <= out_bin_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s == CONV);
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_bin   = out_bin_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_dec_gray2bin_seq.sv
// Self-checking bench for dec_gray2bin_seq: directed vectors, backpressure,
// back-to-back traffic, asynchronous reset mid-conversion and a randomized
// round-trip of every binary value through a Gray encoding.
module tb_dec_gray2bin_seq;
  import enc_pkg::*;

  localparam int W = GRAY_W;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic [W-1:0] q_bin[$];
  int           q_acc[$];

  always #5 clk = ~clk;

  dec_gray2bin_seq_if #(.W(W)) bus ();

  dec_gray2bin_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dec_gray2bin_seq_chk #(.W(W)) chk (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .busy      (bus.busy),
    .out_bin   (bus.out_bin)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each binary bit is the parity of the Gray bits at and above it.
  function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_encode(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 50) begin
      tick();
      edges++;
    end
  endtask

  task automatic send_word(input logic [W-1:0] g);
    check_eq("accept_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_gray  = g;
    tick();
    bus.in_valid = 1'b0;
    bus.in_gray  = W'($urandom);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] g, input logic [W-1:0] exp);
    int e;
    send_word(g);
    check_eq({tag, "_busy"}, bus.busy, 1);
    wait_valid(e);
    check_eq({tag, "_lat"}, e, W - 1);
    check_eq({tag, "_bin"}, bus.out_bin, exp);
    take();
    check_eq({tag, "_drop"}, bus.out_valid, 0);
  endtask

  initial begin
    int e;
    int t1;
    int nxt;
    int loops;
    bit head_seen;
    logic [W-1:0] g;
    logic [W-1:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_gray   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_bin", bus.out_bin, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("idle_ready", bus.in_ready, 1);
    tick();

    directed("g000", 10'h000, 10'h000);
    directed("g3ff", 10'h3FF, 10'h2AA);
    directed("g200", 10'h200, 10'h3FF);
    directed("g001", 10'h001, 10'h001);

    // Backpressure: result must stay put while a competing word is offered.
    g = W'($urandom);
    send_word(g);
    wait_valid(e);
    check_eq("bp_lat", e, W - 1);
    held = bus.out_bin;
    check_eq("bp_bin", held, ref_decode(g));
    bus.in_valid = 1'b1;
    bus.in_gray  = W'($urandom);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("bp_valid", bus.out_valid, 1);
      check_eq("bp_hold", bus.out_bin, ref_decode(g));
      check_eq("bp_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    take();
    check_eq("bp_idle", bus.in_ready, 1);

    // Back-to-back: second word accepted on the edge the first result leaves.
    bus.in_valid  = 1'b1;
    bus.in_gray   = 10'h3FF;
    bus.out_ready = 1'b1;
    tick();
    bus.in_gray = 10'h155;
    wait_valid(e);
    check_eq("b2b_lat1", e, W - 1);
    check_eq("b2b_bin1", bus.out_bin, 10'h2AA);
    check_eq("b2b_ready", bus.in_ready, 1);
    t1 = cyc;
    tick();
    bus.in_valid = 1'b0;
    check_eq("b2b_gap", bus.out_valid, 0);
    check_eq("b2b_busy", bus.busy, 1);
    wait_valid(e);
    check_eq("b2b_space", cyc - t1, W);
    check_eq("b2b_bin2", bus.out_bin, 10'h199);
    tick();
    bus.out_ready = 1'b0;
    check_eq("b2b_done", bus.out_valid, 0);

    // Asynchronous reset while idx == 4, then a clean decode.
    send_word(10'h2C3);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", bus.out_valid, 0);
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_ready", bus.in_ready, 0);
    check_eq("arst_bin", bus.out_bin, 0);
    tick();
    rst = 1'b0;
    e = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.out_valid) e++;
    end
    check_eq("arst_no_partial", e, 0);
    directed("arst_fresh", 10'h155, 10'h199);

    // Randomized round-trip of every binary value with random gaps and
    // backpressure; scoreboard checks order, data and latency.
    nxt       = 0;
    loops     = 0;
    head_seen = 1'b0;
    while ((nxt < (1 << W) || q_bin.size() > 0) && loops < 60000) begin
      if (nxt < (1 << W) && $urandom_range(3, 0) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_gray  = ref_encode(nxt[W-1:0]);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_gray  = W'($urandom);
      end
      bus.out_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (bus.out_valid) begin
        if (q_bin.size() == 0) begin
          check_eq("rt_spurious", bus.out_valid, 0);
        end else begin
          if (!head_seen) begin
            check_eq("rt_lat", cyc - q_acc[0], W - 1);
            head_seen = 1'b1;
          end
          if (bus.out_ready) begin
            check_eq("rt_bin", bus.out_bin, q_bin[0]);
            void'(q_bin.pop_front());
            void'(q_acc.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q_bin.push_back(nxt[W-1:0]);
        q_acc.push_back(cyc + 1);
        nxt++;
      end
      @(posedge clk);
      #1;
      cyc++;
      loops++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("rt_sent", nxt, 1 << W);
    check_eq("rt_drained", q_bin.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dec_gray2bin_seq.md
Name: dec_gray2bin_seq

Overview:
- Iterative Gray-to-binary decoder; inverse of the team's 10-bit binary-to-Gray encoder.
- Accepts one Gray word over a valid/ready handshake.
- Resolves one binary bit per clock, MSB first, using bin[i] = bin[i+1] ^ gray[i].
- Presents the result over a second valid/ready handshake. Used where Gray-coded pointers or positions must be converted back to binary without a long XOR chain in one cycle.

Parameters:
- W, 10, data width in bits (W >= 1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  decoder can accept a word.
- in_gray  input  W  Gray-coded word; sampled only on accept.
- out_valid  output  1  binary result valid.
- out_ready  input  1  downstream accepts the result.
- out_bin  output  W  decoded binary word.
- busy  output  1  high while in CONV.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (port rst, clock clk).
  - While rst is high: state=IDLE, out_valid=0, out_bin=0, busy=0, in_ready=0.
  - in_ready follows state combinationally after rst deasserts.
- States: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid&in_ready (accept edge):
  - g_reg <= in_gray.
  - b_reg[W-1] <= in_gray[W-1]; lower bits of b_reg <= 0.
  - idx <= W-2.
  - Next state CONV, or DONE directly if W==1.
- CONV: busy=1, in_ready=0. Each cycle: b_reg[idx] <= b_reg[idx+1] ^ g_reg[idx].
  - If idx==0, next state DONE; otherwise idx <= idx-1.
- Latency: out_valid rises exactly W-1 edges after the accept edge (9 for W=10; 0 extra edges for W=1, so DONE is reached on the accept edge).
- DONE: out_valid=1; out_bin=b_reg, stable while out_valid=1 and out_ready=0 (no drop, no change).
  - On out_valid&out_ready:
    - If in_valid is also high: the new word is accepted in the same cycle (in_ready=out_ready in DONE); go to CONV, or stay in DONE for W==1.
    - Otherwise go to IDLE.
- Throughput: one word per W cycles with back-to-back traffic.
- in_gray changes while not accepting are ignored. out_bin is a registered output; no combinational path from in_gray to out_bin.
- idx counter width: $clog2(W), minimum 1.
- Reset mid-CONV or mid-DONE: the conversion is abandoned, outputs return to reset values, and no partial result is ever presented.

Decomposition:
- Shared package (enc_pkg):
  - state enum type (IDLE/CONV/DONE).
  - default width constant GRAY_W=10.
- Single module; no sub-module required. The per-bit XOR step is an inline expression.

Test Plan:
- Reset, then in_gray=10'h000 with in_valid pulse -> out_valid after 9 edges, out_bin=10'h000.
- in_gray=10'h3FF -> out_bin=10'h2AA. in_gray=10'h200 -> out_bin=10'h3FF. in_gray=10'h001 -> out_bin=10'h001.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid stays 1, out_bin constant, in_ready=0.
- Back-to-back: in_valid held high with words 10'h3FF then 10'h155, out_ready=1:
  - second word accepted on the same edge the first result is taken.
  - results 10'h2AA then 10'h199 (10'h155 decodes to 0x199), spaced 10 cycles apart.
- Reset asserted at CONV idx=4 -> out_valid=0 and state IDLE immediately (asynchronous). A fresh word after release decodes correctly.
- Exhaustive round-trip: all 1024 binaries through enc_bin2gray into this block -> out_bin equals the original binary; scoreboard checks ordering and the latency of W-1 edges.
